filter_decimator: RTL and testbench



---
 rtl/filter_decimator_pkg.sv | 12 +
 rtl/decim_out_reg.sv | 60 ++++++
 rtl/filter_decimator.sv | 73 +++++++
 tb/tb_filter_decimator.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/filter_decimator_pkg.sv
// Shared defaults and output-register state encoding for the decimating averager.
package filter_decimator_pkg;

    localparam int unsigned NB_DATA_DEF  = 16;
    localparam int unsigned LOG2_DEC_DEF = 2;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_t;

endpackage

// File: rtl/decim_out_reg.sv
// Single-entry valid/ready holding register. A result that arrives while the entry is
// full and not being consumed is dropped and flagged on a sticky overrun bit.
module decim_out_reg
    import filter_decimator_pkg::*;
#(
    parameter int unsigned NB_DATA = NB_DATA_DEF
) (
    input  logic               clock,
    input  logic               i_rst_n,
    input  logic               i_load,
    input  logic [NB_DATA-1:0] i_data,
    input  logic               i_ready,
    input  logic               i_clr_ovr,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_valid,
    output logic               o_overrun
);

    out_state_t         state;
    logic [NB_DATA-1:0] data;
    logic               overrun;

    always_ff @(posedge clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= ST_EMPTY;
            data    <= '0;
            overrun <= 1'b0;
        end else begin
            if (i_clr_ovr) begin
                overrun <= 1'b0;
            end
            case (state)
                ST_EMPTY: begin
                    if (i_load) begin
                        state <= ST_FULL;
                        data  <= i_data;
                    end
                end
                ST_FULL: begin
                    if (i_load) begin
                        // Consumed and refilled on the same edge; otherwise keep the older result.
                        if (i_ready) begin
                            data <= i_data;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end else if (i_ready) begin
                        state <= ST_EMPTY;
                    end
                end
                default: state <= ST_EMPTY;
            endcase
        end
    end

    assign o_data    = data;
    assign o_valid   = (state == ST_FULL);
    assign o_overrun = overrun;

endmodule

// File: rtl/filter_decimator.sv
// Averages blocks of 2**LOG2_DEC filter samples and hands each block mean to a
// stallable downstream stage through a drop-on-full holding register.
module filter_decimator
    import filter_decimator_pkg::*;
#(
    parameter int unsigned NB_DATA  = NB_DATA_DEF,
    parameter int unsigned LOG2_DEC = LOG2_DEC_DEF
) (
    input  logic                clock,
    input  logic                i_rst_n,
    input  logic [NB_DATA-1:0]  i_x,
    input  logic                i_enable,
    input  logic                i_ready,
    input  logic                i_clr_ovr,
    output logic [NB_DATA-1:0]  o_data,
    output logic                o_valid,
    output logic                o_overrun,
    output logic [LOG2_DEC-1:0] o_phase
);

    localparam int unsigned NB_ACC = NB_DATA + LOG2_DEC;

    logic [NB_ACC-1:0]   acc_q;
    logic [NB_ACC-1:0]   acc_d;
    logic [NB_ACC-1:0]   sum;
    logic [LOG2_DEC-1:0] phase_q;
    logic [LOG2_DEC-1:0] phase_d;
    logic                complete;
    logic [NB_DATA-1:0]  result;

    always_comb begin
        sum      = acc_q + {{LOG2_DEC{i_x[NB_DATA-1]}}, i_x};
        // Last sample of the block when the phase counter is at N-1 (all ones).
        complete = i_enable && (&phase_q);
        acc_d    = acc_q;
        phase_d  = phase_q;
        if (i_enable) begin
            phase_d = phase_q + LOG2_DEC'(1);
            acc_d   = complete ? '0 : sum;
        end
    end

    // Dropping the low LOG2_DEC bits of the sign-extended sum is an arithmetic shift
    // with floor rounding; the remaining NB_DATA bits always hold the mean.
    assign result = sum[NB_ACC-1:LOG2_DEC];

    always_ff @(posedge clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc_q   <= '0;
            phase_q <= '0;
        end else begin
            acc_q   <= acc_d;
            phase_q <= phase_d;
        end
    end

    decim_out_reg #(
        .NB_DATA (NB_DATA)
    ) u_out_reg (
        .clock     (clock),
        .i_rst_n   (i_rst_n),
        .i_load    (complete),
        .i_data    (result),
        .i_ready   (i_ready),
        .i_clr_ovr (i_clr_ovr),
        .o_data    (o_data),
        .o_valid   (o_valid),
        .o_overrun (o_overrun)
    );

    assign o_phase = phase_q;

endmodule

// File: tb/tb_filter_decimator.sv
// Directed and random stimulus against a block-mean / single-slot queue model.
module tb_filter_decimator;

    localparam int NB_DATA  = 16;
    localparam int LOG2_DEC = 2;
    localparam int N        = 1 << LOG2_DEC;

    logic                clock = 1'b0;
    logic                i_rst_n;
    logic [NB_DATA-1:0]  i_x;
    logic                i_enable;
    logic                i_ready;
    logic                i_clr_ovr;
    logic [NB_DATA-1:0]  o_data;
    logic                o_valid;
    logic                o_overrun;
    logic [LOG2_DEC-1:0] o_phase;

    filter_decimator #(
        .NB_DATA  (NB_DATA),
        .LOG2_DEC (LOG2_DEC)
    ) dut (
        .clock     (clock),
        .i_rst_n   (i_rst_n),
        .i_x       (i_x),
        .i_enable  (i_enable),
        .i_ready   (i_ready),
        .i_clr_ovr (i_clr_ovr),
        .o_data    (o_data),
        .o_valid   (o_valid),
        .o_overrun (o_overrun),
        .o_phase   (o_phase)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Reference model: samples collected in the open block, plus one output slot.
    int          blk_samples[$];
    bit          m_valid;
    int          m_data;
    bit          m_ovr;

    function automatic int floor_mean(input int s);
        int q;
        q = s / N;
        if ((s % N) != 0 && s < 0) q = q - 1;
        return q;
    endfunction

    task automatic model_reset();
        blk_samples.delete();
        m_valid = 0;
        m_data  = 0;
        m_ovr   = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        logic [NB_DATA-1:0] ed;
        ed = m_data[NB_DATA-1:0];
        chk({tag, ".valid"},   32'(o_valid),   32'(m_valid));
        chk({tag, ".data"},    32'(o_data),    32'(ed));
        chk({tag, ".overrun"}, 32'(o_overrun), 32'(m_ovr));
        chk({tag, ".phase"},   32'(o_phase),   32'(blk_samples.size()));
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then compare.
    task automatic step(input string tag, input bit en, input int x, input bit rdy,
                        input bit clr);
        bit done;
        int res;
        int s;
        i_enable  = en;
        i_x       = x[NB_DATA-1:0];
        i_ready   = rdy;
        i_clr_ovr = clr;
        @(posedge clock);
        done = 0;
        res  = 0;
        if (en) begin
            blk_samples.push_back($signed(x[NB_DATA-1:0]));
            if (blk_samples.size() == N) begin
                s = 0;
                foreach (blk_samples[k]) s += blk_samples[k];
                res  = floor_mean(s);
                done = 1;
                blk_samples.delete();
            end
        end
        if (clr) m_ovr = 0;
        if (!m_valid) begin
            if (done) begin
                m_valid = 1;
                m_data  = res;
            end
        end else if (done) begin
            if (rdy) m_data = res;
            else     m_ovr  = 1;
        end else if (rdy) begin
            m_valid = 0;
        end
        #1;
        chk_all(tag);
    endtask

    task automatic apply_reset();
        #3;
        i_rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst.async.valid",   32'(o_valid),   32'd0);
        chk("rst.async.data",    32'(o_data),    32'd0);
        chk("rst.async.overrun", 32'(o_overrun), 32'd0);
        chk("rst.async.phase",   32'(o_phase),   32'd0);
        @(posedge clock);
        #3;
        i_rst_n = 1'b1;
        #1;
        chk_all("rst.release");
    endtask

    initial begin
        i_rst_n   = 1'b0;
        i_x       = '0;
        i_enable  = 1'b0;
        i_ready   = 1'b0;
        i_clr_ovr = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        chk_all("reset");
        i_rst_n = 1'b1;

        // Constant block of 100, then consume.
        repeat (4) step("const100", 1, 100, 0, 0);
        chk("const100.result", 32'(o_data), 32'd100);
        step("consume", 0, 0, 1, 0);
        chk("consume.empty", 32'(o_valid), 32'd0);

        // Rounding and range extremes, consumed as they complete.
        step("ramp", 1, 1, 1, 0);
        step("ramp", 1, 2, 1, 0);
        step("ramp", 1, 3, 1, 0);
        step("ramp", 1, 4, 1, 0);
        chk("ramp.result", 32'(o_data), 32'd2);
        step("neg", 1, -1, 1, 0);
        step("neg", 1, -1, 1, 0);
        step("neg", 1, -1, 1, 0);
        step("neg", 1, -2, 1, 0);
        chk("neg.result", 32'(o_data), 32'h0000_fffe);
        repeat (4) step("max", 1, 32767, 1, 0);
        chk("max.result", 32'(o_data), 32'h0000_7fff);
        repeat (4) step("min", 1, -32768, 1, 0);
        chk("min.result", 32'(o_data), 32'h0000_8000);
        step("drain", 0, 0, 1, 0);

        // Stalled downstream: first result held, second dropped.
        repeat (8) step("stall5", 1, 5, 0, 0);
        repeat (8) step("stall9", 1, 9, 0, 0);
        chk("stall.held", 32'(o_data), 32'd5);
        chk("stall.ovr",  32'(o_overrun), 32'd1);
        step("clr_ovr", 0, 0, 0, 1);
        chk("clr.ovr", 32'(o_overrun), 32'd0);
        step("drain", 0, 0, 1, 0);

        // Back-to-back blocks with continuous ready: no bubble.
        repeat (4) step("b2b10", 1, 10, 1, 0);
        repeat (4) step("b2b20", 1, 20, 1, 0);
        chk("b2b.result", 32'(o_data), 32'd20);
        step("drain", 0, 0, 1, 0);

        // Gapped enables.
        step("gap", 1, 7, 0, 0);
        step("gap", 0, 7, 0, 0);
        step("gap", 0, 7, 0, 0);
        step("gap", 1, 7, 0, 0);
        step("gap", 0, 7, 0, 0);
        step("gap", 1, 7, 0, 0);
        step("gap", 1, 7, 0, 0);
        chk("gap.result", 32'(o_data), 32'd7);
        step("drain", 0, 0, 1, 0);

        // Reset mid-block discards the partial sum.
        repeat (3) step("part50", 1, 50, 0, 0);
        apply_reset();
        repeat (4) step("post8", 1, 8, 0, 0);
        chk("post8.result", 32'(o_data), 32'd8);

        // Random traffic, including overrun set/clear collisions.
        for (int i = 0; i < 400; i++) begin
            step("rand", ($urandom_range(0, 3) != 0), int'($urandom()),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
